// File: rtl/serial_frame_deserializer.sv
// serial_frame_deserializer: hunts for a sync pattern in a 1-bit stream and assembles the following DATA_W bits (MSB first) into a word.
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   din        : serial data bit
//   din_en     : din valid this cycle; all state holds when 0
//   dout       : last completed word, MSB = first payload bit
//   dout_valid : one-cycle pulse when dout is updated
//   sync_lock  : high while collecting payload (and parity)
//   parity_err : one-cycle pulse on bad even parity (tied 0 unless PARITY_CHK_EN)
//   frame_cnt  : good frames received, 8-bit modulo
// Optional feature: define PARITY_CHK_EN to append and check an even-parity bit after the payload.
module serial_frame_deserializer #(
    parameter int                DATA_W   = 8,
    parameter int                SYNC_W   = 4,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1011
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              din,
    input  logic              din_en,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              sync_lock,
    output logic              parity_err,
    output logic [7:0]        frame_cnt
);
    localparam int CW = $clog2(DATA_W);
    localparam logic [1:0] HUNT    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
`ifdef PARITY_CHK_EN
    localparam logic [1:0] PARITY  = 2'd2;
`endif
    logic [1:0]        state_q, state_d;
    logic [SYNC_W-1:0] sync_q, sync_d, sync_nxt;
    logic [DATA_W-1:0] pay_q, pay_d, word;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic [7:0]        fcnt_q, fcnt_d;
    logic              last;
`ifdef PARITY_CHK_EN
    logic              perr_q, perr_d;
`endif
    assign sync_nxt = {sync_q[SYNC_W-2:0], din};
    assign word     = {pay_q[DATA_W-2:0], din};
    assign last     = cnt_q == CW'(DATA_W - 1);
    always_comb begin
        state_d = state_q;
        sync_d  = sync_q;
        pay_d   = pay_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        fcnt_d  = fcnt_q;
        valid_d = 1'b0;
`ifdef PARITY_CHK_EN
        perr_d  = 1'b0;
`endif
        if (din_en) begin
            case (state_q)
                HUNT: begin
                    // Clearing the shreg on lock means the next hunt starts fresh, so no sync bits carry across frames.
                    if (sync_nxt == SYNC_PAT) begin
                        state_d = COLLECT;
                        sync_d  = '0;
                        cnt_d   = '0;
                    end else begin
                        sync_d = sync_nxt;
                    end
                end
                COLLECT: begin
                    pay_d = word;
                    cnt_d = cnt_q + 1'b1;
                    if (last) begin
                        cnt_d = '0;
`ifdef PARITY_CHK_EN
                        state_d = PARITY;
`else
                        state_d = HUNT;
                        dout_d  = word;
                        valid_d = 1'b1;
                        fcnt_d  = fcnt_q + 8'd1;
`endif
                    end
                end
`ifdef PARITY_CHK_EN
                PARITY: begin
                    state_d = HUNT;
                    // Even parity: payload plus parity bit must hold an even number of ones.
                    if (^{pay_q, din}) begin
                        perr_d = 1'b1;
                    end else begin
                        dout_d  = pay_q;
                        valid_d = 1'b1;
                        fcnt_d  = fcnt_q + 8'd1;
                    end
                end
`endif
                default: state_d = HUNT;
            endcase
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= HUNT;
            sync_q  <= '0;
            pay_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            pay_q   <= pay_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            fcnt_q  <= fcnt_d;
        end
    end
`ifdef PARITY_CHK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) perr_q <= 1'b0;
        else        perr_q <= perr_d;
    end
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif
    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign sync_lock  = state_q != HUNT;
    assign frame_cnt  = fcnt_q;
endmodule

// File: tb/tb_serial_frame_deserializer.sv
// tb_serial_frame_deserializer: directed and randomized bench for serial_frame_deserializer against a bit-queue reference model.
module tb_serial_frame_deserializer;
    localparam int DATA_W = 8;
    localparam int SYNC_W = 4;
    localparam logic [SYNC_W-1:0] PAT = 4'b1011;
`ifdef PARITY_CHK_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FR = SYNC_W + DATA_W + PB;

    logic clk, reset, din, din_en;
    logic [DATA_W-1:0] dout;
    logic dout_valid, sync_lock, parity_err;
    logic [7:0] frame_cnt;

    serial_frame_deserializer #(.DATA_W(DATA_W), .SYNC_W(SYNC_W), .SYNC_PAT(PAT)) dut (
        .clk(clk), .reset(reset), .din(din), .din_en(din_en), .dout(dout),
        .dout_valid(dout_valid), .sync_lock(sync_lock), .parity_err(parity_err), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, lock_cycles = 0, vcount = 0, last_v = -1, gap_bad = 0;
    bit gap_chk = 0;

    // Reference model: bits seen since the hunt began, and payload bits collected since lock.
    bit hunt_q[$];
    bit pay_bits[$];
    bit m_lock = 0, m_valid = 0, m_perr = 0;
    logic [DATA_W-1:0] m_dout = '0;
    int m_fcnt = 0;

    function automatic bit hunt_match();
        int idx;
        bit b;
        for (int i = 0; i < SYNC_W; i++) begin
            idx = hunt_q.size() - SYNC_W + i;
            b = (idx >= 0) ? hunt_q[idx] : 1'b0;
            if (b != PAT[SYNC_W-1-i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [DATA_W-1:0] pay_word();
        int w = 0;
        foreach (pay_bits[i]) w = (w << 1) | int'(pay_bits[i]);
        return DATA_W'(w);
    endfunction

    task automatic model_bit(input bit b);
        int ones;
        if (!m_lock) begin
            hunt_q.push_back(b);
            if (hunt_match()) begin
                m_lock = 1;
                hunt_q.delete();
                pay_bits.delete();
            end
        end else if (pay_bits.size() < DATA_W) begin
            pay_bits.push_back(b);
            if (pay_bits.size() == DATA_W && PB == 0) begin
                m_dout = pay_word();
                m_valid = 1;
                m_fcnt = (m_fcnt + 1) % 256;
                m_lock = 0;
            end
        end else begin
            ones = int'(b);
            foreach (pay_bits[i]) ones += int'(pay_bits[i]);
            if (ones % 2 == 0) begin
                m_dout = pay_word();
                m_valid = 1;
                m_fcnt = (m_fcnt + 1) % 256;
            end else begin
                m_perr = 1;
            end
            m_lock = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("dout", 32'(dout), 32'(m_dout));
        chk("dout_valid", 32'(dout_valid), 32'(m_valid));
        chk("sync_lock", 32'(sync_lock), 32'(m_lock));
        chk("parity_err", 32'(parity_err), 32'(m_perr));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
    endtask

    task automatic step(input logic b, input logic en);
        din = b;
        din_en = en;
        @(posedge clk);
        m_valid = 0;
        m_perr = 0;
        if (en) model_bit(b);
        #1;
        cyc++;
        if (sync_lock) lock_cycles++;
        if (dout_valid) begin
            vcount++;
            if (gap_chk && last_v >= 0 && cyc - last_v != FR) gap_bad++;
            last_v = cyc;
        end
        check_all();
    endtask

    task automatic send_bit(input logic b, input bit gaps);
        step(b, 1'b1);
        if (gaps) step(1'($urandom), 1'b0);
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] w, input bit bad_par, input bit gaps);
        for (int i = 0; i < SYNC_W; i++) send_bit(PAT[SYNC_W-1-i], gaps);
        for (int i = DATA_W - 1; i >= 0; i--) send_bit(w[i], gaps);
        if (PB == 1) send_bit((^w) ^ bad_par, gaps);
    endtask

    task automatic async_reset();
        #3;
        reset = 1'b0;
        #1;
        m_lock = 0; m_valid = 0; m_perr = 0; m_dout = '0; m_fcnt = 0;
        hunt_q.delete();
        pay_bits.delete();
        check_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [6:0] noise;
        reset = 1'b0;
        din = 1'b0;
        din_en = 1'b0;
        #112;
        check_all();
        #1;
        reset = 1'b1;

        // T1: single clean frame
        lock_cycles = 0;
        vcount = 0;
        send_frame(8'hA5, 1'b0, 1'b0);
        chk("t1_dout", 32'(dout), 32'h A5);
        chk("t1_fcnt", 32'(frame_cnt), 32'd1);
        chk("t1_valid_pulses", 32'(vcount), 32'd1);
        chk("t1_lock_cycles", 32'(lock_cycles), 32'(DATA_W + PB));
        step(1'b0, 1'b1);

        // T2: noise must not lock; then overlapping 11011 locks on the 5th bit
        noise = 7'b0110101;
        lock_cycles = 0;
        for (int i = 6; i >= 0; i--) step(noise[i], 1'b1);
        chk("t2_noise_lock", 32'(lock_cycles), 32'd0);
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (DATA_W + 1) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b0);
        chk("t2_overlap_dout", 32'(dout), 32'h3C);
        chk("t2_overlap_valid", 32'(dout_valid), 32'd1);

        // T3: din_en low every other cycle
        vcount = 0;
        send_frame(8'hF0, 1'b0, 1'b1);
        chk("t3_dout", 32'(dout), 32'hF0);
        chk("t3_valid_pulses", 32'(vcount), 32'd1);

        // T4: asynchronous reset mid-frame discards the partial word
        for (int i = 0; i < SYNC_W; i++) step(PAT[SYNC_W-1-i], 1'b1);
        repeat (4) step(1'($urandom), 1'b1);
        async_reset();
        chk("t4_rst_lock", 32'(sync_lock), 32'd0);
        send_frame(8'h81, 1'b0, 1'b0);
        chk("t4_dout", 32'(dout), 32'h81);
        chk("t4_fcnt", 32'(frame_cnt), 32'd1);

        // T5: 256 back-to-back frames wrap frame_cnt to 0
        step(1'b0, 1'b1);
        async_reset();
        vcount = 0;
        gap_bad = 0;
        last_v = -1;
        gap_chk = 1;
        repeat (256) send_frame(8'h55, 1'b0, 1'b0);
        gap_chk = 0;
        chk("t5_pulses", 32'(vcount), 32'd256);
        chk("t5_spacing", 32'(gap_bad), 32'd0);
        chk("t5_fcnt_wrap", 32'(frame_cnt), 32'd0);

`ifdef PARITY_CHK_EN
        // T6: good then bad parity
        send_frame(8'hA5, 1'b0, 1'b0);
        chk("t6_good_valid", 32'(dout_valid), 32'd1);
        chk("t6_good_fcnt", 32'(frame_cnt), 32'd1);
        send_frame(8'hA5, 1'b1, 1'b0);
        chk("t6_bad_perr", 32'(parity_err), 32'd1);
        chk("t6_bad_dout", 32'(dout), 32'hA5);
        chk("t6_bad_fcnt", 32'(frame_cnt), 32'd1);
`endif

        // Random traffic: noise, random payloads, random gaps and parity
        repeat (60) begin
            repeat ($urandom_range(0, 6)) step(1'($urandom), 1'($urandom));
            send_frame(DATA_W'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom));
            if ($urandom_range(0, 9) == 0) async_reset();
        end
        repeat (FR + 2) step(1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
